axis_i2c_arb: RTL and testbench
===============================

# axis_i2c_arb

Round-robin arbiter that shares the single AXI-Stream command path into the I2C master between NUM_REQ independent requesters. Holds a grant for a whole packet (until tlast) so one requester's I2C transaction is never interleaved with another's. Inserts a programmable idle gap after each packet so the I2C master can finish STOP before the next packet. Sits between the requester stream sources and the command FIFO feeding the I2C master.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, tdata width per stream
- GAP_CYCLES, 16, idle cycles between packets (0 allowed)
- TIMEOUT_CYCLES, 1024, stall limit in cycles (used only with watchdog compiled in)
- clk  in  1  clock; all logic on rising edge
- arstn  in  1  reset, synchronous, active-low
- s_tvalid  in  NUM_REQ  per-requester valid
- s_tready  out  NUM_REQ  per-requester ready
- s_tdata  in  NUM_REQ*DATA_WIDTH  requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tlast  in  NUM_REQ  end of packet
- m_tvalid  out  1  to FIFO/I2C master
- m_tready  in  1
- m_tdata  out  DATA_WIDTH
- m_tlast  out  1
- grant  out  NUM_REQ  one-hot current owner, 0 when none
- busy  out  1  high in LOCK or GAP
- timeout_err  out  1  one-cycle pulse on watchdog release (tied 0 without watchdog)

## Operation
- States: IDLE, LOCK, GAP.
- IDLE: grant=0, all s_tready=0, m_tvalid=0. If any s_tvalid, select first requesting index after last_grant in cyclic order (last_grant+1 … wrap); register grant, update last_grant, go LOCK.
- LOCK: m_tvalid/m_tdata/m_tlast = granted requester's signals (combinational mux on registered grant); s_tready[g]=m_tready; all other s_tready=0. Non-granted requesters' valids ignored.
- Handshake with m_tlast=1 in LOCK: next state GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0); grant cleared same edge.
- GAP: counter loads GAP_CYCLES-1 on entry, decrements each cycle; at 0 go IDLE. All tready=0, m_tvalid=0.
- Fairness: requester that just finished is lowest priority at next arbitration.
- Single requester streaming back-to-back packets: re-granted after gap, no starvation of itself.
- Reset: state IDLE, grant=0, last_grant=NUM_REQ-1 (requester 0 wins first), counters 0, busy=0, timeout_err=0, m_tvalid=0, all s_tready=0.
- Reset mid-packet: packet abandoned; no output beat produced in reset cycle; downstream sees truncated packet (system-level concern).
- Widths: gap and timeout counters $clog2(max+1) bits; grant pointer $clog2(NUM_REQ) bits.

## Timing
- Arbitration latency: s_tvalid high in cycle N (state IDLE) -> grant and m_tvalid valid in cycle N+1.
- In LOCK: zero-latency passthrough, one beat per cycle at full throughput.
- Packet turnaround: last handshake cycle T -> earliest next-packet m_tvalid at T+GAP_CYCLES+2 (GAP_CYCLES>0), T+2 (GAP_CYCLES=0).
- busy rises same cycle as grant, falls the cycle state returns to IDLE.
- Requesters must hold tvalid/tdata/tlast stable until tready (AXIS rule); arbiter never drops s_tready[g] while m_tready high.

## Configuration
- Macro AXIS_I2C_ARB_WATCHDOG_EN.
- Defined: in LOCK, counter increments each cycle granted s_tvalid=0, clears on every handshake. Reaching TIMEOUT_CYCLES forces grant release -> GAP, timeout_err high one cycle. Requester's later beats treated as new packet.
- Undefined: no counter; a stalled owner holds grant indefinitely; timeout_err constant 0.

## Structure
- axis_i2c_pkg gains: arb_state_t enum (IDLE, LOCK, GAP), ARB_NUM_REQ, ARB_GAP_CYCLES, ARB_TIMEOUT_CYCLES defaults.
- One sub-module: axis_i2c_rr_pick, combinational round-robin picker (request vector + last_grant in, one-hot + index out, found flag).
- Top FSM, counters and output mux in axis_i2c_arb.

## Test plan
- Reset: arstn=0 two cycles with all valids high -> grant=0, m_tvalid=0, s_tready=0, busy=0.
- Single requester 2 sends 3 bytes 0xA0,0x10,0x55 (tlast on 0x55), m_tready=1 -> m_tdata sequence identical, grant=4'b0100, m_tlast on third beat, busy low GAP_CYCLES+1 cycles after last.
- Requesters 0,1,3 valid simultaneously, 2-beat packets each -> grant order 0,1,3, then 0 again; no interleaving of bytes.
- m_tready toggled 1,0,1,0 during a 4-byte packet -> exactly 4 beats, s_tready[g] mirrors m_tready, other s_tready stay 0.
- GAP_CYCLES=0, requester 1 back-to-back packets -> second packet's first beat 2 cycles after first packet's tlast handshake.
- Watchdog build, TIMEOUT_CYCLES=8: owner drops tvalid after 1 of 3 beats -> timeout_err pulse at 8th idle cycle, grant released, next requester served.

Source files
------------

// File: rtl/axis_i2c_pkg.sv
// axis_i2c_pkg: shared state type and arbiter defaults for the I2C command path
package axis_i2c_pkg;

    typedef enum logic [1:0] {IDLE, LOCK, GAP} arb_state_t;

    localparam int ARB_NUM_REQ        = 4;
    localparam int ARB_GAP_CYCLES     = 16;
    localparam int ARB_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axis_i2c_rr_pick.sv
// axis_i2c_rr_pick: combinational round-robin picker, first request after last_grant in cyclic order
module axis_i2c_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] c;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = IW'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
        grant = found ? NUM_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/axis_i2c_arb.sv
// axis_i2c_arb: packet-locked round-robin AXIS arbiter with post-packet idle gap.
// Optional stall watchdog compiled in with AXIS_I2C_ARB_WATCHDOG_EN.
module axis_i2c_arb
    import axis_i2c_pkg::*;
#(
    parameter int NUM_REQ        = ARB_NUM_REQ,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = ARB_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    output logic [NUM_REQ-1:0]            s_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]            s_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tlast,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] grant_n, pick_oh;
    logic [IW-1:0]      last_grant, last_n, pick_idx;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic               found, hs, wd_fire;

    axis_i2c_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (s_tvalid),
        .last_grant (last_grant),
        .grant      (pick_oh),
        .idx        (pick_idx),
        .found      (found)
    );

    // last_grant doubles as the current owner's index while locked
    assign m_tvalid = arstn && |(grant & s_tvalid);
    assign m_tlast  = |(grant & s_tlast);
    assign m_tdata  = s_tdata[last_grant*DATA_WIDTH +: DATA_WIDTH];
    assign s_tready = (arstn && m_tready) ? grant : '0;
    assign busy     = state != IDLE;
    assign hs       = m_tvalid && m_tready;

`ifdef AXIS_I2C_ARB_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (!arstn || state != LOCK || hs)
            wd_cnt <= '0;
        else if (!m_tvalid)
            wd_cnt <= wd_cnt + TW'(1);
    end

    assign wd_fire     = state == LOCK && !m_tvalid && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign timeout_err = wd_fire;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last_grant;
        gap_n   = gap_cnt;
        unique case (state)
            IDLE: if (found) begin
                state_n = LOCK;
                grant_n = pick_oh;
                last_n  = pick_idx;
            end
            LOCK: if ((hs && m_tlast) || wd_fire) begin
                state_n = GAP_CYCLES > 0 ? GAP : IDLE;
                grant_n = '0;
                gap_n   = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
            end
            GAP: begin
                gap_n   = gap_cnt - GW'(1);
                state_n = gap_cnt == '0 ? IDLE : GAP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_n;
            gap_cnt    <= gap_n;
        end
    end

endmodule

// File: tb/tb_axis_i2c_arb.sv
// tb_axis_i2c_arb: randomized and directed checks against a packet-level round-robin model
module tb_axis_i2c_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GP = 3;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0]    s_tvalid = '0, s_tlast = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic            m_tready = 1'b0;
  logic            sel = 1'b0;
  logic [N-1:0]  rdy_a, rdy_b, gnt_a, gnt_b, rdy, gnt;
  logic          mv_a, mv_b, ml_a, ml_b, busy_a, busy_b, te_a, te_b, mv, ml, busy, te;
  logic [DW-1:0] md_a, md_b, md;
  assign rdy  = sel ? rdy_b  : rdy_a;
  assign gnt  = sel ? gnt_b  : gnt_a;
  assign mv   = sel ? mv_b   : mv_a;
  assign ml   = sel ? ml_b   : ml_a;
  assign md   = sel ? md_b   : md_a;
  assign busy = sel ? busy_b : busy_a;
  assign te   = sel ? te_b   : te_a;
  axis_i2c_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .arstn(arstn), .s_tvalid(s_tvalid), .s_tready(rdy_a), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .m_tvalid(mv_a), .m_tready(m_tready), .m_tdata(md_a), .m_tlast(ml_a),
    .grant(gnt_a), .busy(busy_a), .timeout_err(te_a)
  );
  axis_i2c_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .arstn(arstn), .s_tvalid(s_tvalid), .s_tready(rdy_b), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .m_tvalid(mv_b), .m_tready(m_tready), .m_tdata(md_b), .m_tlast(ml_b),
    .grant(gnt_b), .busy(busy_b), .timeout_err(te_b)
  );
  int errors = 0;
  int checks = 0;
  typedef struct {
    int         idx;
    logic [8:0] b;
  } exp_t;
  logic [8:0] q[N][$];
  exp_t       exp_q[$];
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]         = q[i].size() > 0;
      s_tdata[i*DW +: DW] = q[i].size() > 0 ? q[i][0][7:0] : 8'h00;
      s_tlast[i]          = q[i].size() > 0 ? q[i][0][8] : 1'b0;
    end
  endtask
  task automatic add_byte(input int r, input logic [7:0] b, input logic l);
    q[r].push_back({l, b});
  endtask
  task automatic add_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) q[r].push_back({k == len - 1, 8'($urandom)});
  endtask
  task automatic build_exp();
    int pos[N];
    int last = N - 1;
    int r;
    exp_q.delete();
    for (int i = 0; i < N; i++) pos[i] = 0;
    while (1) begin
      r = -1;
      for (int k = 1; k <= N && r < 0; k++)
        if (pos[(last + k) % N] < q[(last + k) % N].size()) r = (last + k) % N;
      if (r < 0) break;
      do begin
        exp_q.push_back('{r, q[r][pos[r]]});
        pos[r]++;
      end while (!q[r][pos[r]-1][8] && pos[r] < q[r].size());
      last = r;
    end
  endtask
  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    arstn    = 1'b0;
    m_tready = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
  endtask
  task automatic run(input int mode, input int gp, input int max_cyc, output int beats);
    int t_last = -1000;
    int cyc = 0;
    int d;
    logic [N-1:0] pm;
    beats    = 0;
    m_tready = mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
    drive();
    while ((exp_q.size() > 0 || cyc - t_last <= gp + 1) && cyc < max_cyc) begin
      @(negedge clk);
      d = cyc - t_last;
      checks++;
      if (rdy !== (m_tready ? gnt : 4'b0000)) begin
        errors++;
        $display("FAIL ready cyc=%0d got=%b want=%b", cyc, rdy, m_tready ? gnt : 4'b0000);
      end
      checks++;
      if (!$onehot0(gnt) || (gnt != 0 && busy !== 1'b1)) begin
        errors++;
        $display("FAIL grant_busy cyc=%0d grant=%b busy=%b", cyc, gnt, busy);
      end
      if (cyc == 1) begin
        checks++;
        if (mv !== 1'b1) begin errors++; $display("FAIL latency m_tvalid=%b want=1", mv); end
      end
      if (mv === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if (gnt !== N'(1) << exp_q[0].idx) begin
          errors++;
          $display("FAIL owner cyc=%0d grant=%b want=%b", cyc, gnt, N'(1) << exp_q[0].idx);
        end
        checks++;
        if ({ml, md} !== exp_q[0].b) begin
          errors++;
          $display("FAIL data cyc=%0d got=%h want=%h", cyc, {ml, md}, exp_q[0].b);
        end
      end
      if (d >= 1 && d <= gp + 1) begin
        checks++;
        if (mv !== 1'b0 || busy !== (d <= gp)) begin
          errors++;
          $display("FAIL gap d=%0d m_tvalid=%b busy=%b want busy=%b", d, mv, busy, d <= gp);
        end
      end
      if (d == gp + 2 && exp_q.size() > 0) begin
        checks++;
        if (mv !== 1'b1) begin errors++; $display("FAIL turnaround d=%0d m_tvalid=%b want=1", d, mv); end
      end
      pm = s_tvalid & rdy;
      if (mv === 1'b1 && m_tready && exp_q.size() > 0) begin
        beats++;
        if (exp_q[0].b[8]) t_last = cyc;
        void'(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (pm[i]) void'(q[i].pop_front());
      cyc++;
      m_tready = mode == 0 ? 1'b1 : mode == 1 ? ~m_tready : ($urandom_range(0, 3) != 0);
      drive();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain left=%0d want=0", exp_q.size()); end
  endtask
  task automatic test_reset();
    sel      = 1'b0;
    arstn    = 1'b0;
    s_tvalid = '1;
    s_tdata  = 32'($urandom);
    s_tlast  = '1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== '0)    begin errors++; $display("FAIL rst_grant got=%b want=0000", gnt); end
    checks++; if (mv !== 1'b0)   begin errors++; $display("FAIL rst_mvalid got=%b want=0", mv); end
    checks++; if (rdy !== '0)    begin errors++; $display("FAIL rst_ready got=%b want=0000", rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (te !== 1'b0)   begin errors++; $display("FAIL rst_timeout got=%b want=0", te); end
  endtask
  task automatic test_single();
    int beats;
    do_reset();
    add_byte(2, 8'hA0, 1'b0);
    add_byte(2, 8'h10, 1'b0);
    add_byte(2, 8'h55, 1'b1);
    build_exp();
    run(0, GP, 100, beats);
    checks++; if (beats != 3) begin errors++; $display("FAIL single_beats got=%0d want=3", beats); end
  endtask
  task automatic test_rr();
    int beats;
    do_reset();
    repeat (2) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
      add_pkt(3, 2);
    end
    build_exp();
    run(0, GP, 200, beats);
    checks++; if (beats != 12) begin errors++; $display("FAIL rr_beats got=%0d want=12", beats); end
  endtask
  task automatic test_backpressure();
    int beats;
    do_reset();
    add_pkt(3, 4);
    build_exp();
    run(1, GP, 100, beats);
    checks++; if (beats != 4) begin errors++; $display("FAIL bp_beats got=%0d want=4", beats); end
  endtask
  task automatic test_random();
    int beats, total;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      total = 0;
      for (int r = 0; r < N; r++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) begin
          int len = $urandom_range(1, 4);
          add_pkt(r, len);
          total += len;
        end
      end
      build_exp();
      run(2, GP, 2000, beats);
      checks++;
      if (beats != total) begin
        errors++;
        $display("FAIL rand_beats it=%0d got=%0d want=%0d", it, beats, total);
      end
    end
  endtask
  task automatic test_back_to_back_gap0();
    int beats;
    do_reset();
    sel = 1'b1;
    add_pkt(1, 2);
    add_pkt(1, 3);
    build_exp();
    run(0, 0, 100, beats);
    checks++; if (beats != 5) begin errors++; $display("FAIL gap0_beats got=%0d want=5", beats); end
    sel = 1'b0;
  endtask
  task automatic test_stall();
    bit seen;
    do_reset();
    s_tvalid = 4'b0011;
    s_tdata  = {8'h00, 8'h00, 8'h22, 8'h11};
    s_tlast  = 4'b0010;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || mv !== 1'b1 || md !== 8'h11) begin
      errors++;
      $display("FAIL stall_first grant=%b mv=%b data=%h want 0001/1/11", gnt, mv, md);
    end
    @(posedge clk);
    #1 s_tvalid[0] = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_hold k=%0d grant=%b want=0001", k, gnt); end
`ifdef AXIS_I2C_ARB_WATCHDOG_EN
      checks++;
      if (te !== (k == TO)) begin
        errors++;
        $display("FAIL timeout_pulse k=%0d got=%b want=%b", k, te, k == TO);
      end
`else
      checks++;
      if (te !== 1'b0) begin errors++; $display("FAIL timeout_off k=%0d got=%b want=0", k, te); end
`endif
      @(posedge clk);
      #1;
    end
`ifdef AXIS_I2C_ARB_WATCHDOG_EN
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt === 4'b0010) begin
        seen = 1'b1;
        checks++;
        if (md !== 8'h22 || mv !== 1'b1) begin
          errors++;
          $display("FAIL next_owner data=%h mv=%b want 22/1", md, mv);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL release grant=%b want=0010", gnt); end
`else
    seen = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (gnt !== 4'b0001 || te !== 1'b0) seen = 1'b0;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_indefinite grant=%b te=%b want 0001/0", gnt, te); end
`endif
  endtask
  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_random();
    test_back_to_back_gap0();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
